// File: rtl/timer_apb_regif.sv
// -----------------------------------------------------------------------------
// timer_apb_regif
//
// APB responder and register file for the 8-bit timer. Completes CPU
// transfers, holds TDR (reload), TCR (control) and TSR (status), exports the
// control fields to the counter core and latches the core's overflow and
// underflow pulses into TSR.
//
// Register map (byte offsets from BASE_ADDR):
//   +0 TDR  RW  reload value
//   +1 TCR  RW  [7] load, [5] count down, [4] enable, [1:0] clock select;
//               bits 6, 3, 2 ignore writes and read 0
//   +2 TSR  W1C [0] overflow, [1] underflow; bits 7:2 read 0
//   +3 TCNT RO  live counter value; writes are ignored without error
//   Any other address completes with pslverr = 1, reads 0, writes ignored.
//
// Ports:
//   pclk, presetn       clock, asynchronous active-low reset
//   psel, penable,      APB request
//   pwrite, paddr,
//   pwdata
//   prdata, pready,     APB response (all registered)
//   pslverr
//   tdr, tcr_load,      control fields driven into the counter core
//   tcr_dw, tcr_en,
//   tcr_cks
//   ovf_set, udf_set    one-pclk event pulses from the core
//   tcnt_in             live counter value from the core
//   irq_ovf, irq_udf    TSR[0], TSR[1]
//
// Build option:
//   APB_WAIT_STATE_EN   when defined, every transfer gets one wait state
//                       (3 pclk per transfer); otherwise zero-wait (2 pclk).
// -----------------------------------------------------------------------------
module timer_apb_regif #(
    parameter int unsigned            ADDR_WIDTH = 8,
    parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR  = '0
) (
    input  logic                  pclk,
    input  logic                  presetn,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [ADDR_WIDTH-1:0] paddr,
    input  logic [7:0]            pwdata,
    output logic [7:0]            prdata,
    output logic                  pready,
    output logic                  pslverr,
    output logic [7:0]            tdr,
    output logic                  tcr_load,
    output logic                  tcr_dw,
    output logic                  tcr_en,
    output logic [1:0]            tcr_cks,
    input  logic                  ovf_set,
    input  logic                  udf_set,
    input  logic [7:0]            tcnt_in,
    output logic                  irq_ovf,
    output logic                  irq_udf
);

    localparam logic [1:0] REG_TDR  = 2'd0;
    localparam logic [1:0] REG_TCR  = 2'd1;
    localparam logic [1:0] REG_TSR  = 2'd2;
    localparam logic [1:0] REG_TCNT = 2'd3;

    // Writable TCR bits: 7 (load), 5 (down), 4 (enable), 1:0 (clock select).
    localparam logic [7:0] TCR_WMASK = 8'hb3;

    // The SETUP phase is the cycle the bus spends with psel & !penable while
    // the FSM sits in ST_IDLE; the response is decided at the end of that
    // cycle so that pready is already registered when ACCESS begins.
    // ST_WAIT is the first ACCESS cycle when a wait state is inserted;
    // ST_ACCESS is always the completing cycle (pready = 1).
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    state_t                  state;
    logic [7:0]              tcr;
    logic [1:0]              tsr;

    logic [ADDR_WIDTH-1:0]   offset;
    logic                    in_range;
    logic [1:0]              reg_idx;
    logic [7:0]              rd_mux;
    logic [7:0]              rsp_data;
    logic                    wr_en;
    logic [1:0]              w1c;

    // -------------------------------------------------------------------------
    // Address decode, read mux, write strobes
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // through the block leaves a value held and no latch is inferred.
        offset   = paddr - BASE_ADDR;
        in_range = (offset[ADDR_WIDTH-1:2] == '0);
        reg_idx  = offset[1:0];
        rd_mux   = 8'h00;
        if (in_range) begin
            case (reg_idx)
                REG_TDR:  rd_mux = tdr;
                REG_TCR:  rd_mux = tcr;
                REG_TSR:  rd_mux = {6'b0, tsr};
                REG_TCNT: rd_mux = tcnt_in;
                default:  rd_mux = 8'h00;
            endcase
        end
        // Writes return zero on prdata; unmapped reads already mux to zero.
        rsp_data = pwrite ? 8'h00 : rd_mux;
        wr_en    = (state == ST_ACCESS) && psel && penable && pready &&
                   pwrite && in_range;
        w1c      = (wr_en && (reg_idx == REG_TSR)) ? pwdata[1:0] : 2'b00;
    end

    // -------------------------------------------------------------------------
    // APB responder FSM with registered response
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state   <= ST_IDLE;
            pready  <= 1'b0;
            pslverr <= 1'b0;
            prdata  <= 8'h00;
        end else begin
            case (state)
                ST_IDLE: begin
                    // penable without psel is not a transfer and is ignored.
                    if (psel && !penable) begin
`ifdef APB_WAIT_STATE_EN
                        state   <= ST_WAIT;
`else
                        state   <= ST_ACCESS;
                        pready  <= 1'b1;
                        pslverr <= !in_range;
                        prdata  <= rsp_data;
`endif
                    end
                end
                ST_WAIT: begin
                    if (psel && penable) begin
                        state   <= ST_ACCESS;
                        pready  <= 1'b1;
                        pslverr <= !in_range;
                        prdata  <= rsp_data;
                    end else begin
                        // Initiator abandoned the transfer.
                        state   <= ST_IDLE;
                    end
                end
                ST_ACCESS: begin
                    // Completing cycle; a still-high psel is the next SETUP,
                    // picked up from ST_IDLE on the following cycle.
                    state   <= ST_IDLE;
                    pready  <= 1'b0;
                    pslverr <= 1'b0;
                    prdata  <= 8'h00;
                end
                default: begin
                    state   <= ST_IDLE;
                    pready  <= 1'b0;
                    pslverr <= 1'b0;
                    prdata  <= 8'h00;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Register file
    // -------------------------------------------------------------------------
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            tdr <= 8'h00;
            tcr <= 8'h00;
            tsr <= 2'b00;
        end else begin
            if (wr_en && (reg_idx == REG_TDR)) tdr <= pwdata;
            if (wr_en && (reg_idx == REG_TCR)) tcr <= pwdata & TCR_WMASK;
            // A hardware event in the same cycle as a software clear wins.
            tsr[0] <= ovf_set | (tsr[0] & ~w1c[0]);
            tsr[1] <= udf_set | (tsr[1] & ~w1c[1]);
        end
    end

    assign tcr_load = tcr[7];
    assign tcr_dw   = tcr[5];
    assign tcr_en   = tcr[4];
    assign tcr_cks  = tcr[1:0];
    assign irq_ovf  = tsr[0];
    assign irq_udf  = tsr[1];

endmodule

// File: tb/tb_timer_apb_regif.sv
// -----------------------------------------------------------------------------
// tb_timer_apb_regif
//
// Self-checking bench for timer_apb_regif: a directed vector table, hand
// sequences for TCR fields, TSR set/clear races, back-to-back transfers and
// reset during ACCESS, then randomized transfers against a register model.
// Honours APB_WAIT_STATE_EN for the expected transfer length.
// -----------------------------------------------------------------------------
module tb_timer_apb_regif;

    localparam int         AW   = 8;
    localparam logic [7:0] BASE = 8'h00;
`ifdef APB_WAIT_STATE_EN
    localparam int         WAITS = 1;
`else
    localparam int         WAITS = 0;
`endif

    logic          pclk;
    logic          presetn;
    logic          psel;
    logic          penable;
    logic          pwrite;
    logic [AW-1:0] paddr;
    logic [7:0]    pwdata;
    logic [7:0]    prdata;
    logic          pready;
    logic          pslverr;
    logic [7:0]    tdr;
    logic          tcr_load;
    logic          tcr_dw;
    logic          tcr_en;
    logic [1:0]    tcr_cks;
    logic          ovf_set;
    logic          udf_set;
    logic [7:0]    tcnt_in;
    logic          irq_ovf;
    logic          irq_udf;

    timer_apb_regif #(
        .ADDR_WIDTH (AW),
        .BASE_ADDR  (BASE)
    ) dut (
        .pclk     (pclk),
        .presetn  (presetn),
        .psel     (psel),
        .penable  (penable),
        .pwrite   (pwrite),
        .paddr    (paddr),
        .pwdata   (pwdata),
        .prdata   (prdata),
        .pready   (pready),
        .pslverr  (pslverr),
        .tdr      (tdr),
        .tcr_load (tcr_load),
        .tcr_dw   (tcr_dw),
        .tcr_en   (tcr_en),
        .tcr_cks  (tcr_cks),
        .ovf_set  (ovf_set),
        .udf_set  (udf_set),
        .tcnt_in  (tcnt_in),
        .irq_ovf  (irq_ovf),
        .irq_udf  (irq_udf)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    int checks = 0;
    int errors = 0;

    // Reference model: plain register contents as software sees them.
    logic [7:0] m_tdr;
    logic [7:0] m_tcr;
    logic [1:0] m_tsr;

    typedef struct {
        bit         wr;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] tcnt;
        logic [7:0] exp_rd;
        bit         exp_err;
    } vec_t;

    vec_t vecs[14];

    logic [7:0] rd;
    logic       err;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic bit in_map(input logic [7:0] addr);
        return (int'(addr) >= int'(BASE)) && (int'(addr) <= int'(BASE) + 3);
    endfunction

    function automatic logic [7:0] model_read(input logic [7:0] addr);
        if (!in_map(addr)) return 8'h00;
        case (int'(addr) - int'(BASE))
            0:       return m_tdr;
            1:       return m_tcr;
            2:       return {6'b0, m_tsr};
            default: return tcnt_in;
        endcase
    endfunction

    task automatic model_write(input logic [7:0] addr, input logic [7:0] d);
        if (in_map(addr)) begin
            case (int'(addr) - int'(BASE))
                0: m_tdr = d;
                1: m_tcr = {d[7], 1'b0, d[5], d[4], 2'b00, d[1:0]};
                2: m_tsr = m_tsr & ~d[1:0];
                default: ;
            endcase
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_tdr"},  32'(tdr), 32'(m_tdr));
        check({tag, "_tcr"},  32'({tcr_load, tcr_dw, tcr_en, tcr_cks}),
              32'({m_tcr[7], m_tcr[5], m_tcr[4], m_tcr[1:0]}));
        check({tag, "_irq"},  32'({irq_udf, irq_ovf}), 32'(m_tsr));
    endtask

    // One APB transfer. Returns during the completing cycle if keep is set
    // (so the next call forms a back-to-back transfer), otherwise idles the
    // bus after the completing edge. udf_commit pulses udf_set in the
    // completing cycle.
    task automatic xfer(input bit wr, input logic [7:0] addr, input logic [7:0] data,
                        input bit keep, input bit udf_commit,
                        output logic [7:0] rdo, output logic erro);
        int waits;
        bit done;
        rdo  = 8'h00;
        erro = 1'b0;
        @(posedge pclk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data;
        check("pready_low_in_setup", 32'(pready), 0);
        @(posedge pclk); #1;
        penable = 1'b1;
        waits = 0;
        done  = 1'b0;
        for (int i = 0; i < 8 && !done; i++) begin
            if (pready) begin
                done = 1'b1;
            end else begin
                check("prdata_zero_while_waiting", 32'(prdata), 0);
                check("pslverr_zero_while_waiting", 32'(pslverr), 0);
                waits++;
                @(posedge pclk); #1;
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL pready_timeout: got no pready, expected pready within 8 cycles");
        end else begin
            check("wait_states", 32'(waits), 32'(WAITS));
            rdo  = prdata;
            erro = pslverr;
            if (udf_commit) udf_set = 1'b1;
        end
        if (!keep) begin
            @(posedge pclk); #1;
            psel = 1'b0; penable = 1'b0; udf_set = 1'b0;
            check("pready_one_cycle", 32'(pready), 0);
            check("pslverr_after_done", 32'(pslverr), 0);
            check("prdata_after_done", 32'(prdata), 0);
        end
    endtask

    task automatic bus(input bit wr, input logic [7:0] addr, input logic [7:0] data,
                       input bit keep, input bit udf_commit);
        xfer(wr, addr, data, keep, udf_commit, rd, err);
        if (wr) model_write(addr, data);
        if (udf_commit) m_tsr[1] = 1'b1;
    endtask

    task automatic pulse(input bit ovf, input bit udf);
        @(posedge pclk); #1;
        ovf_set = ovf; udf_set = udf;
        @(posedge pclk); #1;
        ovf_set = 1'b0; udf_set = 1'b0;
        if (ovf) m_tsr[0] = 1'b1;
        if (udf) m_tsr[1] = 1'b1;
    endtask

    initial begin
        //           wr    addr   wdata  tcnt   exp_rd exp_err
        vecs[0]  = '{1'b1, 8'h00, 8'h5a, 8'h00, 8'h00, 1'b0};
        vecs[1]  = '{1'b0, 8'h00, 8'h00, 8'h00, 8'h5a, 1'b0};
        vecs[2]  = '{1'b1, 8'h01, 8'hff, 8'h00, 8'h00, 1'b0};
        vecs[3]  = '{1'b0, 8'h01, 8'h00, 8'h00, 8'hb3, 1'b0};
        vecs[4]  = '{1'b1, 8'h10, 8'h77, 8'h00, 8'h00, 1'b1};
        vecs[5]  = '{1'b0, 8'h10, 8'h00, 8'h00, 8'h00, 1'b1};
        vecs[6]  = '{1'b0, 8'h00, 8'h00, 8'h00, 8'h5a, 1'b0};
        vecs[7]  = '{1'b0, 8'h01, 8'h00, 8'h00, 8'hb3, 1'b0};
        vecs[8]  = '{1'b0, 8'h02, 8'h00, 8'h00, 8'h00, 1'b0};
        vecs[9]  = '{1'b0, 8'h03, 8'h00, 8'h3c, 8'h3c, 1'b0};
        vecs[10] = '{1'b1, 8'h03, 8'h99, 8'h3c, 8'h00, 1'b0};
        vecs[11] = '{1'b0, 8'h03, 8'h00, 8'hc5, 8'hc5, 1'b0};
        vecs[12] = '{1'b0, 8'hff, 8'h00, 8'h00, 8'h00, 1'b1};
        vecs[13] = '{1'b1, 8'h04, 8'hee, 8'h00, 8'h00, 1'b1};

        presetn = 1'b0;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = 8'h00;
        ovf_set = 1'b0; udf_set = 1'b0; tcnt_in = 8'h00;
        m_tdr = 8'h00; m_tcr = 8'h00; m_tsr = 2'b00;

        // Reset state
        #3;
        check("reset_prdata",  32'(prdata), 0);
        check("reset_pready",  32'(pready), 0);
        check("reset_pslverr", 32'(pslverr), 0);
        check_outputs("reset");
        #20;
        @(negedge pclk);
        presetn = 1'b1;

        // Directed vector table
        for (int i = 0; i < 14; i++) begin
            tcnt_in = vecs[i].tcnt;
            bus(vecs[i].wr, vecs[i].addr, vecs[i].wdata, 1'b0, 1'b0);
            check($sformatf("vec%0d_pslverr", i), 32'(err), 32'(vecs[i].exp_err));
            if (!vecs[i].wr)
                check($sformatf("vec%0d_prdata", i), 32'(rd), 32'(vecs[i].exp_rd));
        end
        check_outputs("after_table");

        // TCR fields into the core
        bus(1'b1, 8'h01, 8'h82, 1'b0, 1'b0);
        check("tcr82_fields", 32'({tcr_load, tcr_dw, tcr_en, tcr_cks}), 32'(5'b1_0_0_10));
        bus(1'b1, 8'h01, 8'h32, 1'b0, 1'b0);
        check("tcr32_fields", 32'({tcr_load, tcr_dw, tcr_en, tcr_cks}), 32'(5'b0_1_1_10));

        // TSR set / W1C / wrong-bit clear
        pulse(1'b0, 1'b1);
        check("udf_irq", 32'(irq_udf), 1);
        bus(1'b0, 8'h02, 8'h00, 1'b0, 1'b0);
        check("tsr_after_udf", 32'(rd), 32'h02);
        bus(1'b1, 8'h02, 8'h02, 1'b0, 1'b0);
        bus(1'b0, 8'h02, 8'h00, 1'b0, 1'b0);
        check("tsr_after_w1c", 32'(rd), 32'h00);
        pulse(1'b1, 1'b0);
        pulse(1'b1, 1'b0);
        bus(1'b1, 8'h02, 8'h02, 1'b0, 1'b0);
        bus(1'b0, 8'h02, 8'h00, 1'b0, 1'b0);
        check("tsr_wrong_bit_w1c", 32'(rd), 32'h01);
        check("ovf_irq", 32'(irq_ovf), 1);
        bus(1'b1, 8'h02, 8'h01, 1'b0, 1'b0);
        check("ovf_cleared", 32'(irq_ovf), 0);

        // Hardware set beats software clear in the same cycle
        pulse(1'b0, 1'b1);
        bus(1'b1, 8'h02, 8'h02, 1'b0, 1'b1);
        check("set_wins_irq", 32'(irq_udf), 1);
        bus(1'b0, 8'h02, 8'h00, 1'b0, 1'b0);
        check("set_wins_tsr", 32'(rd), 32'h02);
        bus(1'b1, 8'h02, 8'h03, 1'b0, 1'b0);
        check_outputs("after_race");

        // Back-to-back transfers with psel held high
        bus(1'b1, 8'h00, 8'h11, 1'b1, 1'b0);
        bus(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        check("b2b_read", 32'(rd), 32'h11);
        check("b2b_err", 32'(err), 0);

        // Randomized transfers against the model
        for (int n = 0; n < 150; n++) begin
            logic [7:0] a;
            logic [7:0] d;
            logic [7:0] exp_rd;
            bit         w;
            int         r;
            if ($urandom_range(0, 3) == 0)
                pulse(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            r = int'($urandom_range(0, 5));
            a = (r < 4) ? 8'(int'(BASE) + r) : 8'($urandom_range(4, 255));
            w = 1'($urandom_range(0, 1));
            d = 8'($urandom);
            tcnt_in = 8'($urandom);
            exp_rd  = model_read(a);
            bus(w, a, d, 1'b0, 1'b0);
            check("rand_pslverr", 32'(err), 32'(!in_map(a)));
            if (!w) check("rand_prdata", 32'(rd), 32'(exp_rd));
            check_outputs("rand");
        end

        // Reset during ACCESS of a TDR write
        bus(1'b1, 8'h00, 8'h5a, 1'b0, 1'b0);
        @(posedge pclk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h00; pwdata = 8'hab;
        @(posedge pclk); #1;
        penable = 1'b1;
        #3;
        presetn = 1'b0;
        #1;
        m_tdr = 8'h00; m_tcr = 8'h00; m_tsr = 2'b00;
        check("midreset_pready", 32'(pready), 0);
        check("midreset_pslverr", 32'(pslverr), 0);
        check("midreset_tdr", 32'(tdr), 0);
        psel = 1'b0; penable = 1'b0;
        @(posedge pclk); #3;
        presetn = 1'b1;
        @(posedge pclk); #1;
        check_outputs("after_midreset");
        bus(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        check("midreset_tdr_read", 32'(rd), 32'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
